// File: rtl/ioctl_loader_pkg.sv
// Shared types for the ioctl-to-SDRAM loader: FSM states, byte enables,
// and the 42-bit word entry carried through the FIFO.
package ioctl_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_BOTH = 2'b11;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } word_t;

    function automatic word_t mk_word(
        input logic [23:0] a,
        input logic [15:0] d,
        input logic [1:0]  be
    );
        word_t w;
        w.addr = a;
        w.data = d;
        w.be   = be;
        return w;
    endfunction

endpackage

// File: rtl/ioctl_word_fifo.sv
// Word FIFO for packed SDRAM writes; accepts up to two entries per cycle
// so a stray held byte and a new odd byte can be queued together.
import ioctl_loader_pkg::*;

module ioctl_word_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  word_t         i_din,
    input  logic          i_push2,
    input  word_t         i_din2,
    input  logic          i_pop,
    output word_t         o_dout,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full
);

    word_t         r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic          w_wr1;
    logic          w_wr2;
    logic [CW-1:0] w_room;
    logic [CW-1:0] w_nwr;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rp];

    // A slot being popped this cycle is reusable by a push on the same edge.
    assign w_pop  = i_pop && !o_empty;
    assign w_room = CW'(DEPTH) - r_count + CW'(w_pop);
    assign w_wr1  = i_push && (w_room != '0);
    assign w_wr2  = w_wr1 && i_push2 && (w_room >= CW'(2));
    assign w_nwr  = CW'(w_wr1) + CW'(w_wr2);

    always_ff @(posedge clk) begin
        if (w_wr1) r_mem[r_wp] <= i_din;
        if (w_wr2) r_mem[r_wp + AW'(1)] <= i_din2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            r_wp    <= r_wp + w_nwr[AW-1:0];
            r_rp    <= r_rp + AW'(w_pop);
            r_count <= r_count + w_nwr - CW'(w_pop);
        end
    end

endmodule

// File: rtl/ioctl_sdram_loader.sv
// Packs the ioctl byte stream into 16-bit SDRAM writes with byte enables,
// pacing the source through clkref_n and signalling completion.
import ioctl_loader_pkg::*;

module ioctl_sdram_loader #(
    parameter logic [24:0] ADDR_BASE  = 25'd0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        clkref_n,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_be,
    input  logic        mem_ack,
    output logic        loading,
    output logic        load_done,
    output logic [24:0] load_bytes
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t      r_state;
    state_t      w_state_nx;
    logic        r_dl_q;
    logic        r_dl_pend;
    logic        r_hold_v;
    logic [7:0]  r_hold_d;
    logic [23:0] r_hold_a;
    logic        r_clkref_n;
    logic        r_clkref_p;
    logic        r_mem_req;
    word_t       r_req;
    logic        r_loading;
    logic [24:0] r_bytes;

    logic [24:0] w_ea;
    logic        w_rise;
    logic        w_start;
    logic        w_acc;
    logic        w_push;
    logic        w_push2;
    word_t       w_din;
    word_t       w_din2;
    logic        w_hold_set;
    logic        w_hold_clr;
    logic        w_pop;
    word_t       w_head;
    logic [CW-1:0] w_count;
    logic        w_empty;
    logic        w_full;
    logic [CW:0] w_need;
    logic        w_ref_ok;
    word_t       w_held;
    word_t       w_hi;

    assign w_ea   = ADDR_BASE + ioctl_addr;
    assign w_rise = ioctl_download && !r_dl_q;
    assign w_pop  = r_mem_req && mem_ack;
    assign w_held = mk_word(r_hold_a, {8'h00, r_hold_d}, BE_LO);
    assign w_hi   = mk_word(w_ea[24:1], {ioctl_dout, 8'h00}, BE_HI);

    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_acc      = 1'b0;
        w_push     = 1'b0;
        w_push2    = 1'b0;
        w_din      = '0;
        w_din2     = '0;
        w_hold_set = 1'b0;
        w_hold_clr = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (ioctl_download && (w_rise || r_dl_pend)) begin
                    w_state_nx = S_LOAD;
                    w_start    = 1'b1;
                end
            end
            S_LOAD: begin
                if (ioctl_wr) begin
                    w_acc = 1'b1;
                    if (!w_ea[0]) begin
                        w_hold_set = 1'b1;
                        w_push     = r_hold_v;
                        w_din      = w_held;
                    end else if (r_hold_v && r_hold_a == w_ea[24:1]) begin
                        w_push     = 1'b1;
                        w_din      = mk_word(r_hold_a, {ioctl_dout, r_hold_d}, BE_BOTH);
                        w_hold_clr = 1'b1;
                    end else if (r_hold_v) begin
                        w_push     = 1'b1;
                        w_din      = w_held;
                        w_push2    = 1'b1;
                        w_din2     = w_hi;
                        w_hold_clr = 1'b1;
                    end else begin
                        w_push = 1'b1;
                        w_din  = w_hi;
                    end
                end
                if (!ioctl_download) w_state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                if (r_hold_v) begin
                    if (!w_full) begin
                        w_push     = 1'b1;
                        w_din      = w_held;
                        w_hold_clr = 1'b1;
                    end
                end else if (w_empty && !r_mem_req) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Room check also counts pushes landing this cycle, so two slots remain
    // for whatever the next byte may generate.
    assign w_need = (CW+1)'(w_count) + (CW+1)'(w_push) + (CW+1)'(w_push2)
                  + (CW+1)'(2);
    assign w_ref_ok = (r_state == S_LOAD) && ioctl_download
                   && r_clkref_n && r_clkref_p
                   && (w_need <= (CW+1)'(FIFO_DEPTH));

    ioctl_word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_sys),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_push2 (w_push2),
        .i_din2  (w_din2),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_dl_q     <= 1'b0;
            r_dl_pend  <= 1'b0;
            r_hold_v   <= 1'b0;
            r_hold_d   <= '0;
            r_hold_a   <= '0;
            r_clkref_n <= 1'b1;
            r_clkref_p <= 1'b1;
            r_mem_req  <= 1'b0;
            r_req      <= '0;
            r_loading  <= 1'b0;
            r_bytes    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_dl_q  <= ioctl_download;

            if (r_state == S_IDLE)
                r_dl_pend <= 1'b0;
            else if (w_rise && (r_state == S_FLUSH || r_state == S_DONE))
                r_dl_pend <= 1'b1;

            if (w_start) begin
                r_hold_v <= 1'b0;
            end else if (w_hold_set) begin
                r_hold_v <= 1'b1;
                r_hold_d <= ioctl_dout;
                r_hold_a <= w_ea[24:1];
            end else if (w_hold_clr) begin
                r_hold_v <= 1'b0;
            end

            r_clkref_n <= !w_ref_ok;
            r_clkref_p <= r_clkref_n;

            if (w_pop) begin
                r_mem_req <= 1'b0;
            end else if (!r_mem_req && !w_empty) begin
                r_mem_req <= 1'b1;
                r_req     <= w_head;
            end

            if (w_start)
                r_loading <= 1'b1;
            else if (r_state == S_DONE)
                r_loading <= 1'b0;

            if (w_start)
                r_bytes <= '0;
            else if (w_acc && r_bytes != '1)
                r_bytes <= r_bytes + 25'd1;
        end
    end

    assign clkref_n   = r_clkref_n;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_req.addr;
    assign mem_din    = r_req.data;
    assign mem_be     = r_req.be;
    assign loading    = r_loading;
    assign load_done  = (r_state == S_DONE);
    assign load_bytes = r_bytes;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Directed bench for ioctl_sdram_loader with a write scoreboard and an
// auto-acking memory model; the DUT uses ADDR_BASE=1 to exercise wrap.
module tb_ioctl_sdram_loader;

    localparam logic [24:0] BASE = 25'd1;

    typedef struct packed {
        logic [23:0] a;
        logic [15:0] d;
        logic [1:0]  be;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        dl;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        clkref_n;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_be;
    logic        mem_ack;
    logic        loading;
    logic        load_done;
    logic [24:0] load_bytes;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;
    int   stall = 0;
    int   age = 0;

    ioctl_sdram_loader #(
        .ADDR_BASE  (BASE),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_sys        (clk),
        .reset          (reset),
        .ioctl_download (dl),
        .ioctl_wr       (wr),
        .ioctl_addr     (addr),
        .ioctl_dout     (dout),
        .clkref_n       (clkref_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_be         (mem_be),
        .mem_ack        (mem_ack),
        .loading        (loading),
        .load_done      (load_done),
        .load_bytes     (load_bytes)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_wr(input logic [23:0] a, input logic [15:0] d,
                             input logic [1:0] be);
        exp_t e;
        e.a = a; e.d = d; e.be = be;
        q.push_back(e);
    endtask

    // Memory model: ack two cycles into each request unless stalled.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (reset) age = 0;
            else if (stall > 0) stall--;
            else if (mem_req) begin
                age++;
                if (age >= 2) begin
                    mem_ack = 1'b1;
                    age = 0;
                end
            end else age = 0;
        end
    end

    always @(negedge clk) begin
        if (mem_req && mem_ack) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL wr_unexpected observed=%0h required=none", mem_addr);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.a));
                chk("wr_data", 32'(mem_din), 32'(e.d));
                chk("wr_be", 32'(mem_be), 32'(e.be));
            end
        end
        if (load_done) begin
            done_cnt++;
            chk("done_after_last_ack", q.size(), 0);
        end
    end

    task automatic send(input logic [24:0] ea, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (clkref_n !== 1'b0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) begin
            total++;
            bad++;
            $error("FAIL clkref_wait observed=timeout required=low");
        end
        @(posedge clk); #1;
        wr = 1'b1;
        addr = ea - BASE;
        dout = d;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic start_load();
        @(posedge clk); #1;
        dl = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("loading_set", loading, 1);
        chk("bytes_cleared", load_bytes, 0);
    endtask

    task automatic end_load(input int nbytes);
        int d0;
        int n;
        @(posedge clk); #1;
        dl = 1'b0;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("loading_clr", loading, 0);
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt - d0, 1);
        chk("load_bytes", load_bytes, nbytes);
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int d0;
        int n;
        logic [7:0] b;
        reset = 1'b1;
        dl = 1'b0;
        wr = 1'b0;
        addr = '0;
        dout = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_clkref_n", clkref_n, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_loading", loading, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_bytes", load_bytes, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Four bytes, ea 0..3 (ioctl_addr wraps from all-ones)
        expect_wr(24'd0, 16'h2211, 2'b11);
        expect_wr(24'd1, 16'h4433, 2'b11);
        start_load();
        send(25'd0, 8'h11);
        send(25'd1, 8'h22);
        send(25'd2, 8'h33);
        send(25'd3, 8'h44);
        end_load(4);

        // Odd-length file: trailing byte flushed as low byte
        expect_wr(24'd0, 16'hBBAA, 2'b11);
        expect_wr(24'd1, 16'h00CC, 2'b01);
        start_load();
        send(25'd0, 8'hAA);
        send(25'd1, 8'hBB);
        send(25'd2, 8'hCC);
        end_load(3);

        // ioctl_addr 0,1 with base 1: high-only then low-only words
        expect_wr(24'd0, 16'h5500, 2'b10);
        expect_wr(24'd1, 16'h0066, 2'b01);
        start_load();
        send(25'd1, 8'h55);
        send(25'd2, 8'h66);
        end_load(2);

        // Non-sequential bytes: unmatched odd and even-over-held cases
        expect_wr(24'd2, 16'h00A1, 2'b01);
        expect_wr(24'd3, 16'hA200, 2'b10);
        expect_wr(24'd4, 16'h00A3, 2'b01);
        expect_wr(24'd5, 16'h00A4, 2'b01);
        start_load();
        send(25'd4, 8'hA1);
        send(25'd7, 8'hA2);
        send(25'd8, 8'hA3);
        send(25'd10, 8'hA4);
        end_load(4);

        // 64-byte stream with a 40-cycle ack stall
        for (int i = 0; i < 32; i++) begin
            logic [7:0] lo;
            logic [7:0] hi;
            lo = 8'((2 * i) * 5 + 3);
            hi = 8'((2 * i + 1) * 5 + 3);
            expect_wr(24'(i), {hi, lo}, 2'b11);
        end
        stall = 40;
        fork
            begin
                start_load();
                for (int i = 0; i < 64; i++) begin
                    b = 8'(i * 5 + 3);
                    send(25'(i), b);
                end
            end
            begin
                repeat (36) @(negedge clk);
                chk("stall_bytes", load_bytes, 6);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("stall_clkref_high", clkref_n, 1);
                end
            end
        join
        end_load(64);

        // Writes with download low are ignored
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            wr = 1'b1;
            addr = 25'(i);
            dout = 8'hE0;
            @(posedge clk); #1;
            wr = 1'b0;
        end
        repeat (10) begin
            @(negedge clk);
            if (mem_req) seen = 1;
        end
        chk("idle_no_req", seen, 0);
        chk("idle_bytes", load_bytes, 64);

        // Reset while a request is outstanding
        expect_wr(24'd0, 16'h2211, 2'b11);
        start_load();
        send(25'd0, 8'h11);
        send(25'd1, 8'h22);
        n = 0;
        while (mem_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midload_req_seen", mem_req, 1);
        d0 = done_cnt;
        @(posedge clk); #1;
        reset = 1'b1;
        dl = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_loading", loading, 0);
        chk("rst_mid_bytes", load_bytes, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete();
        repeat (20) @(negedge clk);
        chk("rst_mid_no_done", done_cnt, d0);
        chk("rst_mid_no_req", mem_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
